// File: rtl/wrr_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_arbiter
//
// Weighted round-robin arbiter. Each requestor holds the grant for up to
// weight[i] accepted beats. After that, priority rotates to the next
// requestor. The grant is registered as a one-hot vector plus an encoded
// index, and is offered to the consumer with a valid/ready handshake.
//
// Parameters
//   NUM_REQ   number of requestors (>= 2)
//   WEIGHT_W  bits per weight field; max burst = 2**WEIGHT_W-1 beats
//
// Ports
//   clk         clock, all logic on posedge
//   rst         synchronous reset, active-high
//   req         request vector, bit i = requestor i
//   weight      packed weights, weight[i] at [i*WEIGHT_W +: WEIGHT_W]
//   gnt         registered one-hot grant (zero when gnt_valid=0)
//   gnt_enc     registered index of the granted requestor
//   gnt_valid   grant is presented to the consumer
//   gnt_ready   consumer accepts the current beat
//   burst_last  current beat is the last one of the owner's burst
//   lock        (WRR_ARB_LOCK_EN only) owner keeps the grant past its weight
//
// Optional feature macro: WRR_ARB_LOCK_EN
// ---------------------------------------------------------------------------
module wrr_arbiter #(
  parameter int NUM_REQ  = 10,
  parameter int WEIGHT_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*WEIGHT_W-1:0]  weight,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [$clog2(NUM_REQ)-1:0]   gnt_enc,
  output logic                         gnt_valid,
  input  logic                         gnt_ready,
`ifdef WRR_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]           lock,
`endif
  output logic                         burst_last
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0]   NREQ_W   = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] PTR_INIT = IDX_W'(NUM_REQ-1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q, state_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic [IDX_W-1:0]      enc_q, enc_d;
  logic [WEIGHT_W-1:0]   beat_q, beat_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;

  logic [WEIGHT_W-1:0]   w_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    elig;
  logic [WEIGHT_W-1:0]   w_own;
  logic [WEIGHT_W:0]     cnt_nxt;
  logic                  cnt_room;
  logic                  keep_lock;
  logic [IDX_W-1:0]      pick_last;
  logic [IDX_W:0]        pick_res;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;

  // Round-robin pick: the vector is rotated so that bit (last+1) lands at
  // position 0. A fixed-priority search then finds the lowest set bit, and
  // the offset is mapped back to a requestor index. 'last' itself ends up
  // at the top position, so it has the lowest priority.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] e,
                                             input logic [IDX_W-1:0]   last);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W:0]       k_w;
    logic [IDX_W:0]       s;
    dbl = {e, e} >> ({1'b0, last} + 1'b1);
    rot = dbl[NUM_REQ-1:0];
    k_w = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (rot[k]) k_w = (IDX_W+1)'(k);
    end
    s = {1'b0, last} + 1'b1 + k_w;
    if (s >= NREQ_W) s = s - NREQ_W;
    return {|rot, s[IDX_W-1:0]};
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_arr[i] = weight[i*WEIGHT_W +: WEIGHT_W];
      elig[i]  = req[i] & (w_arr[i] != '0);
    end
  end

  // The owner's weight is read live, so lowering it mid-burst takes
  // effect on the next accept.
  assign w_own    = w_arr[enc_q];
  assign cnt_nxt  = {1'b0, beat_q} + 1'b1;
  assign cnt_room = cnt_nxt < {1'b0, w_own};

`ifdef WRR_ARB_LOCK_EN
  assign keep_lock = lock[enc_q] & req[enc_q] & (w_own != '0);
`else
  assign keep_lock = 1'b0;
`endif

  // In IDLE the scan starts after the stored pointer. On a burst switch
  // it starts after the current owner, because the pointer moves to the
  // owner in the same cycle.
  assign pick_last  = (state_q == GRANT) ? enc_q : ptr_q;
  assign pick_res   = rr_pick(elig, pick_last);
  assign pick_found = pick_res[IDX_W];
  assign pick_idx   = pick_res[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    enc_d   = enc_q;
    beat_d  = beat_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANT;
          gnt_d   = onehot(pick_idx);
          enc_d   = pick_idx;
          beat_d  = '0;
        end
      end
      GRANT: begin
        // Without an accept, everything is held. A grant is never
        // withdrawn before the consumer takes the beat.
        if (gnt_ready) begin
          if (keep_lock) begin
            // Locked owner: the count saturates at weight-1 and the
            // pointer stays where it is.
            if (cnt_room) beat_d = cnt_nxt[WEIGHT_W-1:0];
            else          beat_d = w_own - 1'b1;
          end else if (elig[enc_q] && cnt_room) begin
            beat_d = cnt_nxt[WEIGHT_W-1:0];
          end else begin
            ptr_d  = enc_q;
            beat_d = '0;
            if (pick_found) begin
              gnt_d = onehot(pick_idx);
              enc_d = pick_idx;
            end else begin
              state_d = IDLE;
              gnt_d   = '0;
              enc_d   = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        enc_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      enc_q   <= '0;
      beat_q  <= '0;
      ptr_q   <= PTR_INIT;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      enc_q   <= enc_d;
      beat_q  <= beat_d;
      ptr_q   <= ptr_d;
    end
  end

  assign gnt        = gnt_q;
  assign gnt_enc    = enc_q;
  assign gnt_valid  = (state_q == GRANT);
  assign burst_last = gnt_valid & (cnt_nxt >= {1'b0, w_own});

endmodule

// File: tb/tb_wrr_arbiter.sv
module tb_wrr_arbiter;

  localparam int N  = 4;
  localparam int WW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req;
  logic [N*WW-1:0] weight;
  logic [N-1:0]  gnt;
  logic [1:0]    gnt_enc;
  logic          gnt_valid;
  logic          gnt_ready;
  logic          burst_last;
`ifdef WRR_ARB_LOCK_EN
  logic [N-1:0]  lock;
`endif

  int n_vec = 0;
  int n_err = 0;

  wrr_arbiter #(.NUM_REQ(N), .WEIGHT_W(WW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .weight     (weight),
    .gnt        (gnt),
    .gnt_enc    (gnt_enc),
    .gnt_valid  (gnt_valid),
    .gnt_ready  (gnt_ready),
`ifdef WRR_ARB_LOCK_EN
    .lock       (lock),
`endif
    .burst_last (burst_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Weights {1,2,3,1}, all requesting, consumer always ready: expected
  // owner and burst_last per beat.
  logic [1:0] seq_enc  [9] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd1};
  logic       seq_last [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    rst       = 1'b1;
    req       = 4'hF;
    weight    = {4'd1, 4'd3, 4'd2, 4'd1};
    gnt_ready = 1'b1;
`ifdef WRR_ARB_LOCK_EN
    lock      = '0;
`endif
    step();
    step();
    chk("rst_valid", 32'(gnt_valid), 32'd0);
    chk("rst_gnt",   32'(gnt),       32'd0);
    chk("rst_enc",   32'(gnt_enc),   32'd0);

    rst = 1'b0;
    step();
    for (int i = 0; i < 9; i++) begin
      chk("seq_valid", 32'(gnt_valid),  32'd1);
      chk("seq_enc",   32'(gnt_enc),    32'(seq_enc[i]));
      chk("seq_gnt",   32'(gnt),        32'(4'b0001 << seq_enc[i]));
      chk("seq_last",  32'(burst_last), 32'(seq_last[i]));
      if (i < 8) step();
    end

    // Stall mid-burst of owner 1 (beat 0 of 2) and drop its request.
    gnt_ready = 1'b0;
    req       = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_enc",   32'(gnt_enc),    32'd1);
      chk("stall_gnt",   32'(gnt),        32'b0010);
      chk("stall_last",  32'(burst_last), 32'd0);
      chk("stall_valid", 32'(gnt_valid),  32'd1);
    end
    gnt_ready = 1'b1;
    step();
    chk("stall_rel_enc", 32'(gnt_enc), 32'd2);

    // Reset mid-burst, then a zero weight masks requestor 2.
    rst    = 1'b1;
    req    = 4'b0100;
    weight = {4'd1, 4'd0, 4'd2, 4'd1};
    step();
    chk("rst_mid_valid", 32'(gnt_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mask_valid", 32'(gnt_valid), 32'd0);
      chk("mask_gnt",   32'(gnt),       32'd0);
    end
    req = 4'b0101;
    step();
    chk("mask_r0_gnt",   32'(gnt),       32'b0001);
    chk("mask_r0_valid", 32'(gnt_valid), 32'd1);

    // Sole requestor 3 with weight 2 re-wins with a fresh count.
    rst    = 1'b1;
    weight = {4'd2, 4'd0, 4'd2, 4'd1};
    req    = 4'b1000;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("sole_gnt",  32'(gnt),        32'b1000);
      chk("sole_enc",  32'(gnt_enc),    32'd3);
      chk("sole_last", 32'(burst_last), 32'(i % 2));
    end
    rst = 1'b1;
    step();
    chk("sole_rst_valid", 32'(gnt_valid), 32'd0);
    chk("sole_rst_gnt",   32'(gnt),       32'd0);
    rst = 1'b0;

`ifdef WRR_ARB_LOCK_EN
    rst    = 1'b1;
    weight = {4'd1, 4'd3, 4'd1, 4'd1};
    req    = 4'hF;
    lock   = 4'b0010;
    step();
    rst = 1'b0;
    step();
    chk("lock_first", 32'(gnt_enc), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("lock_own", 32'(gnt_enc), 32'd1);
    end
    lock = '0;
    step();
    chk("lock_drop", 32'(gnt_enc), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
